// File: rtl/cnn_stage_pkg.sv
// Shared types for the CNN frame stager: reader FSM states and the tagged result record.
package cnn_stage_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_STREAM,
    R_WAIT
  } rd_state_t;

  localparam int DEF_TAG_BITS = 4;
  localparam int DEF_BCD_BITS = 4;

  typedef struct packed {
    logic [DEF_TAG_BITS-1:0] tag;
    logic [DEF_BCD_BITS-1:0] digit;
  } result_t;

endpackage

// File: rtl/cnn_result_fifo.sv
// First-word fall-through synchronous FIFO with an occupancy count; head reads as 0 when empty.
module cnn_result_fifo
  import cnn_stage_pkg::*;
#(
  parameter type T     = result_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  T                    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  // NOTE: storage arrays are left unreset so they map onto plain RAM; the
  // pointers and count alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // The reader reserves a slot before streaming, so this never fires.
      assert (!(push && count == CNT_BITS'(DEPTH)));
    end
  end

endmodule

// File: rtl/cnn_frame_stager.sv
// Ping-pong frame stager: buffers whole frames, replays them to the CNN core as
// gap-free bursts, and queues the tagged digit results for a ready/valid consumer.
module cnn_frame_stager
  import cnn_stage_pkg::*;
#(
  parameter int GS_BITS        = 8,
  parameter int BCD_BITS       = 4,
  parameter int IMG_W          = 28,
  parameter int IMG_H          = 28,
  parameter int PIX_ADDR_BITS  = 10,
  parameter int RES_FIFO_DEPTH = 4,
  parameter int TAG_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GS_BITS-1:0]  pixel_i,
  input  logic                pixel_i_valid,
  input  logic                pixel_i_last,
  output logic                pixel_i_ready,
  output logic [GS_BITS-1:0]  core_pixel_o,
  output logic                core_pixel_o_valid,
  input  logic [BCD_BITS-1:0] core_digit_i,
  input  logic                core_digit_i_valid,
  output logic [BCD_BITS-1:0] digit_o,
  output logic [TAG_BITS-1:0] digit_tag_o,
  output logic                digit_o_valid,
  input  logic                digit_o_ready,
  output logic                frame_err_o
);

  localparam int N        = IMG_W * IMG_H;
  localparam int CNT_BITS = $clog2(RES_FIFO_DEPTH + 1);
  localparam logic [PIX_ADDR_BITS-1:0] LAST_IDX = PIX_ADDR_BITS'(N - 1);

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [BCD_BITS-1:0] digit;
  } stage_result_t;

  logic [GS_BITS-1:0]       bank_mem [2 * 2**PIX_ADDR_BITS];
  logic [1:0]               full;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [PIX_ADDR_BITS-1:0] wr_cnt;
  logic [PIX_ADDR_BITS-1:0] rd_cnt;
  logic [TAG_BITS-1:0]      wr_tag;
  logic [TAG_BITS-1:0]      bank_tag [2];
  rd_state_t                rd_state;
  logic [GS_BITS-1:0]       rd_data;
  logic                     pix_valid;

  logic                     in_xfer;
  logic                     frame_close;
  logic                     rd_start;
  logic                     rd_issue;
  logic [PIX_ADDR_BITS-1:0] rd_idx;
  logic                     result_take;
  logic [CNT_BITS-1:0]      fifo_count;
  stage_result_t            push_data;
  stage_result_t            fifo_head;

  assign pixel_i_ready = ~full[wr_bank];
  assign in_xfer       = pixel_i_valid & pixel_i_ready;
  assign frame_close   = in_xfer & pixel_i_last & (wr_cnt == LAST_IDX);

  // Address 0 is read on the IDLE->STREAM edge so the burst starts two cycles after the last pixel.
  assign rd_start    = (rd_state == R_IDLE) & full[rd_bank]
                       & (fifo_count < CNT_BITS'(RES_FIFO_DEPTH));
  assign rd_issue    = rd_start | (rd_state == R_STREAM);
  assign rd_idx      = (rd_state == R_STREAM) ? rd_cnt : '0;
  assign result_take = (rd_state == R_WAIT) & core_digit_i_valid;

  assign core_pixel_o_valid = pix_valid;
  assign core_pixel_o       = pix_valid ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (in_xfer)  bank_mem[{wr_bank, wr_cnt}] <= pixel_i;
    if (rd_issue) rd_data <= bank_mem[{rd_bank, rd_idx}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      wr_tag      <= '0;
      bank_tag[0] <= '0;
      bank_tag[1] <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (in_xfer) begin
        if (pixel_i_last || wr_cnt == LAST_IDX) begin
          wr_cnt <= '0;
          if (frame_close) begin
            bank_tag[wr_bank] <= wr_tag;
            wr_tag            <= wr_tag + 1'b1;
            wr_bank           <= ~wr_bank;
          end else begin
            frame_err_o <= 1'b1;
          end
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Writer and reader always own different banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (frame_close) full[wr_bank] <= 1'b1;
      if (result_take) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd_issue;
      case (rd_state)
        R_IDLE: begin
          if (rd_start) begin
            rd_state <= R_STREAM;
            rd_cnt   <= PIX_ADDR_BITS'(1);
          end
        end
        R_STREAM: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_IDX) rd_state <= R_WAIT;
        end
        R_WAIT: begin
          if (core_digit_i_valid) begin
            rd_bank  <= ~rd_bank;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign push_data = '{tag: bank_tag[rd_bank], digit: core_digit_i};

  cnn_result_fifo #(
    .T     (stage_result_t),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (result_take),
    .push_data (push_data),
    .pop       (digit_o_ready),
    .head      (fifo_head),
    .valid     (digit_o_valid),
    .count     (fifo_count)
  );

  assign digit_o     = fifo_head.digit;
  assign digit_tag_o = fifo_head.tag;

endmodule

// File: tb/tb_cnn_frame_stager.sv
// Self-checking bench for cnn_frame_stager: random pixel frames, a behavioural core
// model with programmable answer delay, and a frame-level scoreboard of pixels and results.
module tb_cnn_frame_stager;

  localparam int GS_BITS        = 8;
  localparam int BCD_BITS       = 4;
  localparam int IMG_W          = 28;
  localparam int IMG_H          = 28;
  localparam int PIX_ADDR_BITS  = 10;
  localparam int RES_FIFO_DEPTH = 4;
  localparam int TAG_BITS       = 4;
  localparam int N              = IMG_W * IMG_H;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [GS_BITS-1:0]  pixel_i = '0;
  logic                pixel_i_valid = 1'b0;
  logic                pixel_i_last = 1'b0;
  logic                pixel_i_ready;
  logic [GS_BITS-1:0]  core_pixel_o;
  logic                core_pixel_o_valid;
  logic [BCD_BITS-1:0] core_digit_i;
  logic                core_digit_i_valid;
  logic [BCD_BITS-1:0] digit_o;
  logic [TAG_BITS-1:0] digit_tag_o;
  logic                digit_o_valid;
  logic                digit_o_ready = 1'b0;
  logic                frame_err_o;

  cnn_frame_stager #(
    .GS_BITS        (GS_BITS),
    .BCD_BITS       (BCD_BITS),
    .IMG_W          (IMG_W),
    .IMG_H          (IMG_H),
    .PIX_ADDR_BITS  (PIX_ADDR_BITS),
    .RES_FIFO_DEPTH (RES_FIFO_DEPTH),
    .TAG_BITS       (TAG_BITS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pixel_i            (pixel_i),
    .pixel_i_valid      (pixel_i_valid),
    .pixel_i_last       (pixel_i_last),
    .pixel_i_ready      (pixel_i_ready),
    .core_pixel_o       (core_pixel_o),
    .core_pixel_o_valid (core_pixel_o_valid),
    .core_digit_i       (core_digit_i),
    .core_digit_i_valid (core_digit_i_valid),
    .digit_o            (digit_o),
    .digit_tag_o        (digit_tag_o),
    .digit_o_valid      (digit_o_valid),
    .digit_o_ready      (digit_o_ready),
    .frame_err_o        (frame_err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int core_delay = 10;
  bit stray_req = 1'b0;
  int run = 0;
  int err_pulses = 0;
  int zero_viol = 0;
  int model_tag = 0;
  int core_seen[$];
  int exp_px[$];
  int burst_lens[$];
  int burst_start[$];
  int resp_due[$];
  int resp_edges[$];
  int answers[$];
  int exp_res[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Core model and output monitor: records every burst, answers after core_delay cycles.
  initial begin : core_model
    core_digit_i       = '0;
    core_digit_i_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        run = 0;
        resp_due.delete();
      end else begin
        if (frame_err_o) err_pulses++;
        if (core_pixel_o_valid) begin
          if (run == 0) burst_start.push_back(cyc);
          core_seen.push_back(int'(core_pixel_o));
          run++;
        end else begin
          if (core_pixel_o != '0) zero_viol++;
          if (run != 0) begin
            burst_lens.push_back(run);
            resp_due.push_back(cyc + core_delay);
            run = 0;
          end
        end
      end
      #2;
      core_digit_i_valid = 1'b0;
      core_digit_i       = '0;
      if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
        void'(resp_due.pop_front());
        core_digit_i_valid = 1'b1;
        if (answers.size() != 0) core_digit_i = BCD_BITS'(answers.pop_front());
        resp_edges.push_back(cyc + 1);
      end else if (stray_req) begin
        stray_req          = 1'b0;
        core_digit_i_valid = 1'b1;
        core_digit_i       = BCD_BITS'(9);
      end
    end
  end

  task automatic clear_model();
    core_seen.delete();
    exp_px.delete();
    burst_lens.delete();
    burst_start.delete();
    resp_edges.delete();
    answers.delete();
    exp_res.delete();
    model_tag  = 0;
    err_pulses = 0;
    zero_viol  = 0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    pixel_i_valid = 1'b0;
    pixel_i_last  = 1'b0;
    digit_o_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    clear_model();
  endtask

  // A good frame has len==N with last on the final pixel; anything else must be dropped.
  task automatic send_frame(input int len, input int last_at, input int digit,
                            output int last_edge, output logic err_seen);
    int px[$];
    int guard;
    last_edge = -1;
    err_seen  = 1'b0;
    for (int i = 0; i < len; i++) begin
      px.push_back(int'($urandom_range(0, 255)));
      pixel_i       = GS_BITS'(px[i]);
      pixel_i_valid = 1'b1;
      pixel_i_last  = (i == last_at);
      guard = 0;
      while (!pixel_i_ready && guard < 6000) begin
        tick();
        guard++;
      end
      if (!pixel_i_ready) begin
        check("ingress_stall", pixel_i_ready, 1);
        pixel_i_valid = 1'b0;
        pixel_i_last  = 1'b0;
        return;
      end
      tick();
      last_edge = cyc;
    end
    pixel_i_valid = 1'b0;
    pixel_i_last  = 1'b0;
    err_seen      = frame_err_o;
    if (len == N && last_at == N - 1) begin
      foreach (px[i]) exp_px.push_back(px[i]);
      answers.push_back(digit);
      exp_res.push_back(model_tag * 16 + digit);
      model_tag = (model_tag + 1) % (1 << TAG_BITS);
    end
  endtask

  task automatic wait_bursts(input int n, input string tag);
    int g = 0;
    while (burst_lens.size() < n && g < 8000) begin
      tick();
      g++;
    end
    check(tag, burst_lens.size(), n);
  endtask

  task automatic pop_result(input string tag);
    int g = 0;
    int want = 0;
    while (!digit_o_valid && g < 8000) begin
      tick();
      g++;
    end
    check({tag, "_valid"}, digit_o_valid, 1);
    if (exp_res.size() != 0) want = exp_res.pop_front();
    check({tag, "_tag"}, digit_tag_o, want / 16);
    check({tag, "_digit"}, digit_o, want % 16);
    digit_o_ready = 1'b1;
    tick();
    digit_o_ready = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int mism = 0;
    int bad_len = 0;
    check({tag, "_px_count"}, core_seen.size(), exp_px.size());
    foreach (exp_px[i]) if (i >= core_seen.size() || core_seen[i] != exp_px[i]) mism++;
    check({tag, "_px_data"}, mism, 0);
    foreach (burst_lens[i]) if (burst_lens[i] != N) bad_len++;
    check({tag, "_burst_len"}, bad_len, 0);
    check({tag, "_idle_zero"}, zero_viol, 0);
  endtask

  initial begin : stimulus
    int   le;
    int   rise;
    int   g;
    logic es;

    // 1: single frame, core answers 7
    do_reset();
    check("rst_ready", pixel_i_ready, 1);
    check("rst_core_valid", core_pixel_o_valid, 0);
    check("rst_core_pixel", core_pixel_o, 0);
    check("rst_digit_valid", digit_o_valid, 0);
    check("rst_digit", digit_o, 0);
    check("rst_tag", digit_tag_o, 0);
    check("rst_err", frame_err_o, 0);
    core_delay = 20;
    send_frame(N, N - 1, 7, le, es);
    check("t1_no_err", es, 0);
    wait_bursts(1, "t1_burst");
    check("t1_latency", (burst_start.size() != 0) ? burst_start[0] : -1, le + 2);
    pop_result("t1_res");
    check("t1_empty_after_pop", digit_o_valid, 0);
    stray_req = 1'b1;
    tick(4);
    check("t1_stray_ignored", digit_o_valid, 0);
    check("t1_no_extra_burst", burst_lens.size(), 1);
    check_stream("t1");

    // 2: three frames back-to-back, slow core
    do_reset();
    core_delay = 1000;
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    check("t2_ready_drop", pixel_i_ready, 0);
    g = 0;
    while (!pixel_i_ready && g < 3000) begin
      tick();
      g++;
    end
    rise = cyc;
    check("t2_ready_rise", rise, (resp_edges.size() != 0) ? resp_edges[0] : -1);
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    pop_result("t2_res0");
    pop_result("t2_res1");
    pop_result("t2_res2");
    check_stream("t2");

    // 3: last too early, then a good frame takes tag 0
    do_reset();
    core_delay = 10;
    send_frame(501, 500, 0, le, es);
    check("t3_err_pulse", es, 1);
    tick();
    check("t3_err_once", frame_err_o, 0);
    check("t3_err_count", err_pulses, 1);
    tick(5);
    check("t3_no_burst", burst_lens.size(), 0);
    check("t3_ready", pixel_i_ready, 1);
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    pop_result("t3_res");

    // 4: missing last, bank stays empty, next good frame takes tag 1
    send_frame(N, -1, 0, le, es);
    check("t4_err_pulse", es, 1);
    tick(10);
    check("t4_err_count", err_pulses, 2);
    check("t4_no_burst", burst_lens.size(), 1);
    check("t4_ready", pixel_i_ready, 1);
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    pop_result("t4_res");
    check_stream("t34");

    // 5: consumer stalled, FIFO fills, fifth frame waits for a pop
    do_reset();
    core_delay = 5;
    for (int f = 0; f < 5; f++) send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    wait_bursts(4, "t5_four_bursts");
    tick(50);
    check("t5_held_burst", burst_lens.size(), 4);
    check("t5_fifo_valid", digit_o_valid, 1);
    pop_result("t5_res0");
    wait_bursts(5, "t5_fifth_burst");
    for (int f = 1; f < 5; f++) pop_result($sformatf("t5_res%0d", f));
    check_stream("t5");

    // 6: reset mid-stream, then a fresh frame
    do_reset();
    core_delay = 10;
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    g = 0;
    while (core_seen.size() < 300 && g < 2000) begin
      tick();
      g++;
    end
    check("t6_reached_px300", core_seen.size() >= 300, 1);
    rst = 1'b1;
    tick();
    check("t6_core_valid", core_pixel_o_valid, 0);
    check("t6_ready", pixel_i_ready, 1);
    check("t6_digit_valid", digit_o_valid, 0);
    rst = 1'b0;
    clear_model();
    send_frame(N, N - 1, int'($urandom_range(0, 9)), le, es);
    wait_bursts(1, "t6_burst");
    pop_result("t6_res");
    check_stream("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
